// File: rtl/memory_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------------+
// | memory_responder: one single-port word RAM serving fetch, load and store ports |
// | with fixed-latency valid pulses. MEMORY_RESPONDER_ROUND_ROBIN_EN: round-robin. |
// | Rev 1.0                                                                        |
// +--------------------------------------------------------------------------------+
module memory_responder #(
  parameter int    WIDTH     = 32,
  parameter int    ADDR_BITS = 12,
  parameter int    LATENCY   = 1,
  parameter string INIT_FILE = ""
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] ia,
  input  logic             ia_enable,
  output logic [WIDTH-1:0] iv,
  output logic             iv_valid,
  input  logic [WIDTH-1:0] da_in,
  input  logic             da_in_enable,
  output logic [WIDTH-1:0] dv_in,
  output logic             dv_in_valid,
  input  logic [WIDTH-1:0] da_out,
  input  logic             da_out_enable,
  input  logic [WIDTH-1:0] dv_out,
  output logic             dv_out_valid
);

  localparam int         DEPTH        = 2 ** ADDR_BITS;
  localparam logic [3:0] c_count_init = 4'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;
  typedef enum logic [1:0] {P_FETCH, P_LOAD, P_STORE} port_t;

  logic [WIDTH-1:0]     mem [DEPTH];
  state_t               r_state, w_next_state;
  port_t                r_port, w_win, w_rd_port;
  logic [ADDR_BITS-1:0] r_idx, w_win_idx, w_rd_idx;
  logic [3:0]           r_count, w_next_count;
  logic [2:0]           w_pending;
  logic                 w_busy, w_grant, w_rd_en, w_wr_en;
  logic                 w_unused_addr_bits;

  assign w_unused_addr_bits = ^{ia[1:0], da_in[1:0], da_out[1:0],
                                ia[WIDTH-1:ADDR_BITS+2], da_in[WIDTH-1:ADDR_BITS+2],
                                da_out[WIDTH-1:ADDR_BITS+2]};

  // The port currently being served (including its DONE cycle) cannot re-request.
  assign w_busy       = (r_state != S_IDLE);
  assign w_pending[0] = ia_enable     && !(w_busy && r_port == P_FETCH);
  assign w_pending[1] = da_in_enable  && !(w_busy && r_port == P_LOAD);
  assign w_pending[2] = da_out_enable && !(w_busy && r_port == P_STORE);
  assign w_grant      = (r_state != S_ACCESS) && (|w_pending);

`ifdef MEMORY_RESPONDER_ROUND_ROBIN_EN
  logic [1:0] r_rr;

  function automatic port_t rr_pick(input logic [1:0] ptr, input logic [2:0] pend);
    port_t      pick;
    logic [1:0] c;
    pick = P_FETCH;
    for (int k = 2; k >= 0; k--) begin
      c = 2'((int'(ptr) + k) % 3);
      if (pend[c]) pick = port_t'(c);
    end
    return pick;
  endfunction

  assign w_win = rr_pick(r_rr, w_pending);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)     r_rr <= 2'd0;
    else if (w_grant) r_rr <= (w_win == P_STORE) ? 2'd0 : 2'(w_win) + 2'd1;
  end
`else
  assign w_win = w_pending[2] ? P_STORE : (w_pending[1] ? P_LOAD : P_FETCH);
`endif

  always_comb begin
    w_win_idx = ia[ADDR_BITS+1:2];
    case (w_win)
      P_LOAD:  w_win_idx = da_in[ADDR_BITS+1:2];
      P_STORE: w_win_idx = da_out[ADDR_BITS+1:2];
      default: w_win_idx = ia[ADDR_BITS+1:2];
    endcase
  end

  always_comb begin
    w_next_state = r_state;
    w_next_count = r_count;
    case (r_state)
      S_ACCESS: begin
        w_next_count = r_count - 4'd1;
        if (r_count <= 4'd1) w_next_state = S_DONE;
      end
      default: begin
        w_next_state = S_IDLE;
        if (w_grant) begin
          w_next_state = (LATENCY == 1) ? S_DONE : S_ACCESS;
          w_next_count = c_count_init;
        end
      end
    endcase
  end

  // The RAM read happens on the edge that enters DONE, so reads see every earlier store.
  generate
    if (LATENCY == 1) begin : g_rd_direct
      logic w_unused_idx;
      assign w_unused_idx = ^r_idx;
      assign w_rd_en      = w_grant && (w_win != P_STORE);
      assign w_rd_port    = w_win;
      assign w_rd_idx     = w_win_idx;
    end else begin : g_rd_latched
      assign w_rd_en   = (r_state == S_ACCESS) && (r_count <= 4'd1) && (r_port != P_STORE);
      assign w_rd_port = r_port;
      assign w_rd_idx  = r_idx;
    end
  endgenerate

  assign w_wr_en = w_grant && (w_win == P_STORE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_port  <= P_FETCH;
      r_idx   <= '0;
      r_count <= '0;
      iv      <= '0;
      dv_in   <= '0;
    end else begin
      r_state <= w_next_state;
      r_count <= w_next_count;
      if (w_grant) begin
        r_port <= w_win;
        r_idx  <= w_win_idx;
      end
      if (w_rd_en) begin
        if (w_rd_port == P_FETCH) iv <= mem[w_rd_idx];
        else                      dv_in <= mem[w_rd_idx];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_wr_en) mem[w_win_idx] <= dv_out;
  end

  assign iv_valid     = (r_state == S_DONE) && (r_port == P_FETCH);
  assign dv_in_valid  = (r_state == S_DONE) && (r_port == P_LOAD);
  assign dv_out_valid = (r_state == S_DONE) && (r_port == P_STORE);

endmodule
`default_nettype wire
